xbar_sel_gen: RTL and testbench
===============================

# xbar_sel_gen

Select-bus generator and data stager for the distribution crossbar. It accepts one input vector plus a per-lane replication count, then emits one or more registered beats. Each beat carries the data bus, a per-PE mux select bus and a per-PE valid mask, ready to drive the crossbar's data and select inputs directly. Replicas are packed contiguously onto PEs in lane order. A vector whose total replica count exceeds NUM_PES spills across multiple beats.

## Interface
- DATA_TYPE, 16: element width in bits
- NUM_PES, 64: multiplier count; number of select fields per beat
- INPUT_BW, 64: lanes per input vector; must satisfy INPUT_BW <= 2^LOG2_PES
- LOG2_PES, 6: select field width
- LOG2_BW, 6: ceil(log2(INPUT_BW))
- Derived: CNT_W = LOG2_PES+1; TOT_W = LOG2_PES+LOG2_BW+1

Ports:
- clk, input, 1, single clock; all logic on rising edge
- rst, input, 1, synchronous, active-low reset
- s_valid, input, 1, input vector valid
- s_ready, output, 1, block can accept a vector
- s_data_bus, input, INPUT_BW*DATA_TYPE, lane data; lane l is at [l*DATA_TYPE +: DATA_TYPE]
- s_count_bus, input, INPUT_BW*CNT_W, replication count for lane l, range 0..NUM_PES
- o_valid, output, 1, beat valid (one-cycle pulse per beat)
- o_last, output, 1, final beat of the current vector
- o_data_bus, output, INPUT_BW*DATA_TYPE, captured vector, stable for all beats
- o_mux_bus, output, LOG2_PES*NUM_PES, select for PE p at [p*LOG2_PES +: LOG2_PES]
- o_pe_valid, output, NUM_PES, PE p carries a real replica in this beat

## Operation
- FSM has two states: IDLE and EMIT. s_ready = (state == IDLE).
- Accept fires on a rising edge where s_valid && s_ready. On accept:
  - Capture data and counts. Counts above NUM_PES are clamped to NUM_PES.
  - Compute total = sum of clamped counts (TOT_W bits, no overflow possible).
  - Clear base to 0.
  - If total == 0, stay in IDLE and emit no beat. Otherwise go to EMIT.
- Prefix sums: prefix[0] = 0 and prefix[l+1] = prefix[l] + count[l]. These are computed from the captured counts.
- For each EMIT cycle and each PE p, let g = base + p:
  - If g < total: select = the unique lane l with prefix[l] <= g < prefix[l+1], and pe_valid[p] = 1. Zero-count lanes are never selected.
  - If g >= total: select = 0 and pe_valid[p] = 0.
- Each EMIT cycle registers one beat, then base += NUM_PES.
  - If base + NUM_PES >= total, the beat has o_last = 1 and the FSM returns to IDLE.
- There is no output backpressure; the crossbar consumes every beat.
- Between beats (o_valid = 0): o_mux_bus and o_pe_valid hold 0, and o_data_bus holds the last captured vector.
- Reset (rst = 0 at an edge) clears every register, including mid-EMIT. Any partially emitted vector is dropped with no o_last.

## Timing
- Reset values: s_ready = 1 (once out of reset), o_valid = 0, o_last = 0, o_mux_bus = 0, o_pe_valid = 0, o_data_bus = 0. State resets to IDLE, base to 0.
- Latency:
  - Accept at edge E0.
  - Beat k (k = 0..n-1) is registered at edge E(k+1), where n = ceil(total/NUM_PES).
  - o_valid is high for exactly n consecutive cycles.
- s_ready goes low after E0 and returns high after E(n), the edge that registers the last beat.
  - The earliest next accept is E(n+1), so there is one idle output cycle between vectors.
- A zero-total vector: s_ready stays high, and a new accept is possible at E1.
- o_data_bus updates at E0. It is stable from E1 through all beats of that vector.

## Structure
- Shared package xbar_pkg holds:
  - width helpers CNT_W and TOT_W
  - FSM state enum {IDLE, EMIT}
  - the count clamp function
- Sub-module xbar_lane_search: one instance per PE. Takes g, total and the prefix array. Returns the select field and pe_valid bit, using a combinational compare with priority encoding. The top level holds the FSM, capture registers, prefix adder chain, base counter and output registers.

## Test plan
- Every count = 1 (INPUT_BW = NUM_PES = 64) -> one beat with o_last = 1, select[p] = p, o_pe_valid all ones.
- Lane 3 count = 64, others 0 -> one beat, every select = 3, o_pe_valid all ones.
- Lane 0 = 40, lane 1 = 40 -> two beats:
  - Beat 0: PE0–39 select 0, PE40–63 select 1, o_last = 0.
  - Beat 1: PE0–15 select 1, o_pe_valid = 0x000000000000FFFF, PE16–63 select 0, o_last = 1.
- All counts 0 -> no o_valid, s_ready never drops, next vector accepted on the following edge.
- Lane 0 count = 100 (clamped to 64) -> single beat, all selects 0.
- Two vectors back-to-back, each with total 128 -> beats at E1, E2, accept at E3, beats at E4, E5.
- rst low at E1 during a two-beat vector -> outputs zero at that edge, no o_last, and s_ready = 1 once rst is released.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar select-bus generator.
package xbar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Count field width: needs to hold 0..2^log2_pes inclusive.
    function automatic int cnt_w(input int log2_pes);
        return log2_pes + 1;
    endfunction

    // Total replica width: up to INPUT_BW lanes of NUM_PES replicas each.
    function automatic int tot_w(input int log2_pes, input int log2_bw);
        return log2_pes + log2_bw + 1;
    endfunction

    // Saturate a replication count at the number of PEs.
    function automatic logic [31:0] clamp_count(input logic [31:0] cnt, input logic [31:0] max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/xbar_lane_search.sv
// Per-PE lane lookup: finds which input lane owns global replica slot g.
module xbar_lane_search
    import xbar_pkg::*;
#(
    parameter int INPUT_BW = 64,
    parameter int LOG2_PES = 6,
    parameter int TOT_W    = 13
) (
    input  logic [TOT_W-1:0]              g_i,
    input  logic [TOT_W-1:0]              total_i,
    input  logic [(INPUT_BW+1)*TOT_W-1:0] prefix_i,
    output logic [LOG2_PES-1:0]           sel_o,
    output logic                          pe_valid_o
);

    // Interval match against the prefix sums; zero-count lanes have an empty
    // interval and can never match. Scanning high-to-low gives lowest lane priority.
    always_comb begin
        sel_o      = '0;
        pe_valid_o = 1'b0;
        if (g_i < total_i) begin
            pe_valid_o = 1'b1;
            for (int l = INPUT_BW - 1; l >= 0; l--) begin
                if ((g_i >= prefix_i[l*TOT_W +: TOT_W]) &&
                    (g_i <  prefix_i[(l+1)*TOT_W +: TOT_W])) begin
                    sel_o = LOG2_PES'(l);
                end
            end
        end
    end

endmodule

// File: rtl/xbar_sel_gen.sv
// Select-bus generator and data stager for the distribution crossbar.
// Captures one vector with per-lane replica counts and emits one or more
// beats of packed replica selects, NUM_PES slots per beat.
//
// state | meaning
// IDLE  | ready for a new vector; outputs held at zero
// EMIT  | emitting one beat per cycle until all replicas are covered
module xbar_sel_gen
    import xbar_pkg::*;
#(
    parameter  int DATA_TYPE = 16,
    parameter  int NUM_PES   = 64,
    parameter  int INPUT_BW  = 64,
    parameter  int LOG2_PES  = 6,
    parameter  int LOG2_BW   = 6,
    localparam int CNT_W     = cnt_w(LOG2_PES),
    localparam int TOT_W     = tot_w(LOG2_PES, LOG2_BW)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [INPUT_BW*DATA_TYPE-1:0] s_data_bus,
    input  logic [INPUT_BW*CNT_W-1:0]     s_count_bus,
    output logic                          o_valid,
    output logic                          o_last,
    output logic [INPUT_BW*DATA_TYPE-1:0] o_data_bus,
    output logic [LOG2_PES*NUM_PES-1:0]   o_mux_bus,
    output logic [NUM_PES-1:0]            o_pe_valid
);

    state_e                          state_q;
    logic [TOT_W-1:0]                base_q;
    logic [TOT_W-1:0]                total_q;
    logic [CNT_W-1:0]                cnt_q [INPUT_BW];
    logic [INPUT_BW*DATA_TYPE-1:0]   data_q;
    logic                            o_valid_q;
    logic                            o_last_q;
    logic [LOG2_PES*NUM_PES-1:0]     o_mux_q;
    logic [NUM_PES-1:0]              o_pe_valid_q;

    logic [CNT_W-1:0]                cnt_clamp_d [INPUT_BW];
    logic [TOT_W-1:0]                total_d;
    logic [(INPUT_BW+1)*TOT_W-1:0]   prefix_d;
    logic [LOG2_PES*NUM_PES-1:0]     sel_d;
    logic [NUM_PES-1:0]              pe_valid_d;
    logic                            last_beat_d;

    // Clamp incoming counts and sum them so the zero-total case is known at accept.
    always_comb begin
        total_d = '0;
        for (int l = 0; l < INPUT_BW; l++) begin
            cnt_clamp_d[l] = CNT_W'(clamp_count(32'(s_count_bus[l*CNT_W +: CNT_W]), NUM_PES));
            total_d        = total_d + TOT_W'(cnt_clamp_d[l]);
        end
    end

    // Prefix adder chain over the captured counts: entry l is the first slot of lane l.
    always_comb begin
        logic [TOT_W-1:0] acc;
        acc      = '0;
        prefix_d = '0;
        for (int l = 0; l < INPUT_BW; l++) begin
            acc = acc + TOT_W'(cnt_q[l]);
            prefix_d[(l+1)*TOT_W +: TOT_W] = acc;
        end
    end

    generate
        for (genvar p = 0; p < NUM_PES; p++) begin : gen_pe
            logic [TOT_W-1:0] g_w;
            assign g_w = base_q + TOT_W'(p);

            xbar_lane_search #(
                .INPUT_BW (INPUT_BW),
                .LOG2_PES (LOG2_PES),
                .TOT_W    (TOT_W)
            ) u_search (
                .g_i        (g_w),
                .total_i    (total_q),
                .prefix_i   (prefix_d),
                .sel_o      (sel_d[p*LOG2_PES +: LOG2_PES]),
                .pe_valid_o (pe_valid_d[p])
            );
        end
    endgenerate

    assign last_beat_d = ((base_q + TOT_W'(NUM_PES)) >= total_q);

    // FSM, capture registers, base counter and registered beat outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            total_q      <= '0;
            data_q       <= '0;
            for (int l = 0; l < INPUT_BW; l++) begin
                cnt_q[l] <= '0;
            end
            o_valid_q    <= 1'b0;
            o_last_q     <= 1'b0;
            o_mux_q      <= '0;
            o_pe_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_valid_q    <= 1'b0;
                    o_last_q     <= 1'b0;
                    o_mux_q      <= '0;
                    o_pe_valid_q <= '0;
                    if (s_valid) begin
                        data_q  <= s_data_bus;
                        for (int l = 0; l < INPUT_BW; l++) begin
                            cnt_q[l] <= cnt_clamp_d[l];
                        end
                        total_q <= total_d;
                        base_q  <= '0;
                        if (total_d != '0) begin
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    o_valid_q    <= 1'b1;
                    o_last_q     <= last_beat_d;
                    o_mux_q      <= sel_d;
                    o_pe_valid_q <= pe_valid_d;
                    base_q       <= base_q + TOT_W'(NUM_PES);
                    if (last_beat_d) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign s_ready    = (state_q == IDLE);
    assign o_valid    = o_valid_q;
    assign o_last     = o_last_q;
    assign o_data_bus = data_q;
    assign o_mux_bus  = o_mux_q;
    assign o_pe_valid = o_pe_valid_q;

endmodule

// File: tb/tb_xbar_sel_gen.sv
// Scoreboard bench for xbar_sel_gen: a replica-list model pushes expected
// beats at accept time; a negedge monitor pops and compares them.
module tb_xbar_sel_gen;

    localparam int DT  = 16;
    localparam int NP  = 64;
    localparam int BW  = 64;
    localparam int LP  = 6;
    localparam int LB  = 6;
    localparam int CW  = LP + 1;
    localparam int DW  = BW * DT;
    localparam int CBW = BW * CW;
    localparam int MW  = LP * NP;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data_bus = '0;
    logic [CBW-1:0] s_count_bus = '0;
    logic           o_valid;
    logic           o_last;
    logic [DW-1:0]  o_data_bus;
    logic [MW-1:0]  o_mux_bus;
    logic [NP-1:0]  o_pe_valid;

    typedef struct {
        logic [MW-1:0] mux;
        logic [NP-1:0] pev;
        logic          last;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;

    xbar_sel_gen #(
        .DATA_TYPE (DT),
        .NUM_PES   (NP),
        .INPUT_BW  (BW),
        .LOG2_PES  (LP),
        .LOG2_BW   (LB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data_bus  (s_data_bus),
        .s_count_bus (s_count_bus),
        .o_valid     (o_valid),
        .o_last      (o_last),
        .o_data_bus  (o_data_bus),
        .o_mux_bus   (o_mux_bus),
        .o_pe_valid  (o_pe_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: cyc equals the index of the posedge just before this negedge.
    always @(negedge clk) begin
        beat_t e;
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_beat", 512'(1), 512'(0));
            end else begin
                e = sb.pop_front();
                chk("beat_cycle", 512'(cyc), 512'(e.cyc));
                chk("mux_bus",    512'(o_mux_bus), 512'(e.mux));
                chk("pe_valid",   512'(o_pe_valid), 512'(e.pev));
                chk("last",       512'(o_last), 512'(e.last));
                chk("data_lo",    o_data_bus[511:0], e.data[511:0]);
                chk("data_hi",    o_data_bus[1023:512], e.data[1023:512]);
            end
        end else begin
            chk("idle_outs", 512'({o_last, o_pe_valid, o_mux_bus}), 512'(0));
        end
        cyc = cyc + 1;
    end

    // Independent model: expand counts into a flat list of lane ids, slice by NP.
    task automatic push_expected(input logic [DW-1:0] d, input logic [CBW-1:0] c, input int acc);
        int lanes[$];
        int total;
        int n;
        int cnt;
        for (int l = 0; l < BW; l++) begin
            cnt = int'(c[l*CW +: CW]);
            if (cnt > NP) cnt = NP;
            repeat (cnt) lanes.push_back(l);
        end
        total = lanes.size();
        n = (total + NP - 1) / NP;
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.mux  = '0;
            b.pev  = '0;
            for (int p = 0; p < NP; p++) begin
                if (k * NP + p < total) begin
                    b.mux[p*LP +: LP] = LP'(lanes[k*NP + p]);
                    b.pev[p] = 1'b1;
                end
            end
            b.last = (k == n - 1);
            b.data = d;
            b.cyc  = acc + k + 1;
            sb.push_back(b);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CBW-1:0] c, output int acc);
        @(negedge clk);
        s_data_bus  = d;
        s_count_bus = c;
        s_valid     = 1'b1;
        for (int i = 0; i < 200 && !s_ready; i++) @(negedge clk);
        if (!s_ready) begin
            chk("ready_timeout", 512'(0), 512'(1));
            s_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        acc = cyc;
        push_expected(d, c, acc);
        #1 s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_empty", 512'(sb.size()), 512'(0));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int l = 0; l < BW; l++) d[l*DT +: DT] = DT'($urandom);
        return d;
    endfunction

    function automatic logic [CBW-1:0] fill_cnt(input int v);
        logic [CBW-1:0] c;
        for (int l = 0; l < BW; l++) c[l*CW +: CW] = CW'(v);
        return c;
    endfunction

    initial begin
        logic [CBW-1:0] c;
        logic [DW-1:0]  d;
        int a0, a1;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  512'(o_valid), 512'(0));
        chk("rst_ready",  512'(s_ready), 512'(1));
        chk("rst_data",   o_data_bus[511:0], 512'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 512'(s_ready), 512'(1));

        // every lane count 1: identity selects
        d = rand_data();
        send(d, fill_cnt(1), a0);
        drain();
        chk("hold_data", o_data_bus[511:0], d[511:0]);

        // lane 3 replicated across all PEs
        c = '0; c[3*CW +: CW] = CW'(64);
        send(rand_data(), c, a0);
        drain();

        // 40 + 40: spills into a second beat
        c = '0; c[0 +: CW] = CW'(40); c[CW +: CW] = CW'(40);
        send(rand_data(), c, a0);
        drain();

        // zero total: no beat, ready stays high, next accept on the following edge
        d = rand_data();
        send(d, '0, a0);
        chk("zero_ready", 512'(s_ready), 512'(1));
        send(rand_data(), fill_cnt(1), a1);
        chk("zero_next_accept", 512'(a1 - a0), 512'(1));
        drain();

        // clamp: 100 -> 64
        c = '0; c[0 +: CW] = CW'(100);
        send(rand_data(), c, a0);
        drain();

        // back-to-back two-beat vectors
        send(rand_data(), fill_cnt(2), a0);
        c = '0; c[5*CW +: CW] = CW'(64); c[10*CW +: CW] = CW'(30); c[20*CW +: CW] = CW'(34);
        send(rand_data(), c, a1);
        chk("b2b_gap", 512'(a1 - a0), 512'(3));
        drain();

        // random counts, including zeros and over-range values
        for (int t = 0; t < 4; t++) begin
            c = '0;
            for (int l = 0; l < BW; l++) begin
                if ($urandom_range(0, 7) == 0) c[l*CW +: CW] = CW'($urandom_range(0, 127));
                else                           c[l*CW +: CW] = CW'($urandom_range(0, 3));
            end
            send(rand_data(), c, a0);
            drain();
        end

        // reset in the middle of a two-beat vector
        c = '0; c[0 +: CW] = CW'(40); c[CW +: CW] = CW'(40);
        send(rand_data(), c, a0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rstmid_valid", 512'(o_valid), 512'(0));
        chk("rstmid_last",  512'(o_last), 512'(0));
        chk("rstmid_pev",   512'(o_pe_valid), 512'(0));
        chk("rstmid_data",  o_data_bus[511:0], 512'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", 512'(s_ready), 512'(1));
        send(rand_data(), fill_cnt(1), a0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
